// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream (sync, 16-bit word count, LE payload, XOR checksum)
// into IMEM writes, then releases core_en on a clean load. One write cycle per assembled word.
module imem_boot_loader #(
  parameter int         I_WIDTH   = 32,
  parameter int         IMEM_SZ   = 2**15,
  parameter int         ADDR_W    = $clog2(IMEM_SZ),
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [I_WIDTH-1:0] imem_wdata,
  output logic               core_en,
  output logic               boot_done,
  output logic               boot_err,
  output logic [15:0]        words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT0, S_CNT1, S_DATA, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_SZ);

  state_t      state, state_nxt;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] n_rx;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic [23:0] word_buf;
  logic        accept;
  logic        restart;

  assign rx_ready = (state == S_SYNC) || (state == S_CNT0) || (state == S_CNT1) ||
                    (state == S_DATA) || (state == S_CHK);
  assign accept    = rx_valid && rx_ready;
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign n_rx      = {rx_data, n_lo};
  assign imem_we   = (state == S_WR);
  assign core_en   = (state == S_DONE);
  assign boot_done = (state == S_DONE);
  assign boot_err  = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SYNC;
      S_SYNC:  if (accept && rx_data == SYNC_BYTE) state_nxt = S_CNT0;
      S_CNT0:  if (accept) state_nxt = S_CNT1;
      S_CNT1: begin
        if (accept) begin
          if ({1'b0, n_rx} > MAX_WORDS) state_nxt = S_ERR;
          else if (n_rx == 16'd0)       state_nxt = S_CHK;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_idx == 2'd3) state_nxt = S_WR;
      // word_idx still holds the pre-increment value here
      S_WR:    state_nxt = (word_idx + 16'd1 == n_words) ? S_CHK : S_DATA;
      S_CHK:   if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_nxt = S_SYNC;
      S_ERR:   if (start) state_nxt = S_SYNC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lo         <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      word_buf     <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      if (restart) words_loaded <= '0;
      case (state)
        S_CNT0: if (accept) n_lo <= rx_data;
        S_CNT1: begin
          if (accept) begin
            n_words      <= n_rx;
            byte_idx     <= '0;
            word_idx     <= '0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Latch the write port only when a word completes so it holds between writes
                imem_addr  <= word_idx[ADDR_W-1:0];
                imem_wdata <= {rx_data, word_buf};
              end
            endcase
          end
        end
        S_WR: begin
          word_idx     <= word_idx + 16'd1;
          words_loaded <= words_loaded + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized frame bench for imem_boot_loader checked against a byte-stream reference model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [14:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_en;
  logic        boot_done;
  logic        boot_err;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame[$];
  logic [46:0] wr_q[$];
  logic [46:0] exp_w[$];
  bit          exp_done, exp_err;
  int          exp_words;

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_en(core_en), .boot_done(boot_done), .boot_err(boot_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && imem_we) wr_q.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_done"}, boot_done, 0);
    check({tag, "_err"}, boot_err, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_words"}, words_loaded, 0);
    check({tag, "_ready"}, rx_ready, 0);
  endtask

  // All driver tasks enter and leave on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("rx_ready_timeout", guard, 0);
    else @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Whole-image reference: find sync, read count, consume LE words, XOR-check.
  task automatic ref_model();
    int i = 0;
    int n;
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    exp_w.delete();
    exp_done = 0; exp_err = 0; exp_words = 0;
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    n = int'(frame[i+1]) + 256 * int'(frame[i+2]);
    i += 3;
    if (n > 32768) begin
      exp_err = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w  = {frame[i+3], frame[i+2], frame[i+1], frame[i]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_w.push_back({15'(k), w});
      exp_words++;
      i += 4;
    end
    if (frame[i] == cs) exp_done = 1;
    else                exp_err  = 1;
  endtask

  task automatic build_frame(input int n, input int garbage, input bit corrupt);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    frame.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      frame.push_back(b == 8'hA5 ? 8'h5A : b);
    end
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    if (n > 32768) return;
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom_range(0, 255));
      cs ^= b;
      frame.push_back(b);
    end
    frame.push_back(cs ^ {7'd0, corrupt});
  endtask

  task automatic compare(input string tag);
    check({tag, "_wr_count"}, wr_q.size(), exp_w.size());
    for (int k = 0; k < wr_q.size() && k < exp_w.size(); k++)
      check({tag, "_wr"}, wr_q[k], exp_w[k]);
    check({tag, "_done"}, boot_done, exp_done);
    check({tag, "_err"}, boot_err, exp_err);
    check({tag, "_core_en"}, core_en, exp_done);
    check({tag, "_words"}, words_loaded, exp_words);
  endtask

  task automatic run_frame(input string tag);
    wr_q.delete();
    pulse_start();
    foreach (frame[k]) send_byte(frame[k]);
    @(negedge clk);
    ref_model();
    compare(tag);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_quiet("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    // Two-word image; XOR of payload bytes 13^93^10 = 90
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("two_word");
    check("two_word_w0", wr_q.size() > 0 ? wr_q[0] : 47'h0, {15'd0, 32'h00000013});
    check("two_word_w1", wr_q.size() > 1 ? wr_q[1] : 47'h0, {15'd1, 32'h00100093});

    frame[11] = 8'h91;
    run_frame("bad_cs");

    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_frame("garbage");

    build_frame(32769, 0, 0);
    run_frame("oversize");

    build_frame(0, 0, 0);
    run_frame("empty");
    check("empty_cs_byte", frame[3], 8'h00);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 7) == 0) build_frame($urandom_range(32769, 65535), $urandom_range(0, 3), 0);
      else build_frame($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      run_frame("random");
    end

    // Largest legal count proceeds into payload; abort with reset after one word
    wr_q.delete();
    pulse_start();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h80);
    check("max_n_err", boot_err, 0);
    check("max_n_ready", rx_ready, 1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check("max_n_wr_count", wr_q.size(), 1);
    check("max_n_wr", wr_q.size() > 0 ? wr_q[0] : 47'h0, {15'd0, 32'h44332211});
    check("max_n_words", words_loaded, 1);
    do_reset();

    // Reset after five payload bytes, then a clean reload
    wr_q.delete();
    pulse_start();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
    check("abort_wr_count", wr_q.size(), 1);
    do_reset();
    build_frame(3, 1, 0);
    run_frame("reload");

    // start during DATA must be ignored
    build_frame(2, 0, 0);
    wr_q.delete();
    pulse_start();
    for (int k = 0; k < 6; k++) send_byte(frame[k]);
    pulse_start();
    for (int k = 6; k < frame.size(); k++) send_byte(frame[k]);
    @(negedge clk);
    ref_model();
    compare("start_in_data");

    // Restart from DONE clears status immediately
    pulse_start();
    check("restart_done", boot_done, 0);
    check("restart_core_en", core_en, 0);
    check("restart_words", words_loaded, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
